// File: rtl/dram_burst_reader.sv
// dram_burst_reader: streams a block of DRAM words into a FIFO and out on a valid/ready stream.
// Reads are only issued while buffered plus in-flight words fit the FIFO, so any DRAM latency is safe.
module dram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] dram_addr_rd,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] dram_data_rd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  err_unexp
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         len_q, len_d, issued_q, issued_d, popped_q, popped_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d, pend_q, pend_d;
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  issue, push, pop;

    always_comb begin
        issue    = state_q == ISSUE && issued_q < len_q && (cnt_q + pend_q) < CW'(FIFO_DEPTH);
        push     = dram_valid && pend_q != '0;
        pop      = cnt_q != '0 && out_ready;
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q + NW'(issue);
        popped_d = popped_q + NW'(pop);
        addr_d   = issue ? addr_q + ADDR_WIDTH'(1) : addr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        pend_d   = pend_q + CW'(issue) - CW'(push);
        wp_d     = push ? wp_q + PW'(1) : wp_q;
        rp_d     = pop ? rp_q + PW'(1) : rp_q;
        err_d    = err_q || (dram_valid && pend_q == '0);
        unique case (state_q)
            IDLE: if (start) begin
                len_d    = {1'b0, length};
                issued_d = '0;
                popped_d = '0;
                addr_d   = base_addr;
                state_d  = length == '0 ? DONE : ISSUE;
            end
            ISSUE:   state_d = issued_d == len_q ? DRAIN : ISSUE;
            DRAIN:   state_d = popped_d == len_q ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= dram_data_rd;
    end

    // out_data is forced to zero when empty so reset and idle show a clean bus
    assign busy         = state_q == ISSUE || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign dram_en_rd   = issue;
    assign dram_addr_rd = addr_q;
    assign out_valid    = cnt_q != '0;
    assign out_data     = out_valid ? mem_q[rp_q] : '0;
    assign err_unexp    = err_q;
endmodule

// File: tb/tb_dram_burst_reader.sv
// tb_dram_burst_reader: directed checks of dram_burst_reader against a latency-programmable DRAM model.
module tb_dram_burst_reader;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0, arst = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, dram_en_rd, out_valid, err_unexp;
    logic [AW-1:0] dram_addr_rd;
    logic          dram_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] dram_data_rd = '0, out_data;

    always #5 clk = ~clk;

    dram_burst_reader dut (
        .clk(clk), .arst(arst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
        .dram_valid(dram_valid), .dram_data_rd(dram_data_rd),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err_unexp(err_unexp)
    );

    int vectors = 0, errors = 0;
    int cyc = 0, lat = 2, occ = 0, max_occ = 0, last_pop = 0;
    logic stray = 1'b0, real_v = 1'b0;
    logic [AW-1:0] req_q[$], rd_addr[$];
    int due_q[$], rd_cyc[$];
    logic [DW-1:0] got[$];

    function automatic logic [DW-1:0] dword(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {14'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Commits what the coming edge will see, then advances one cycle and drives DRAM returns.
    task automatic step();
        if (dram_en_rd) begin
            req_q.push_back(dram_addr_rd);
            due_q.push_back(cyc + lat);
            rd_addr.push_back(dram_addr_rd);
            rd_cyc.push_back(cyc);
        end
        if (dram_valid && real_v) occ++;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            occ--;
            last_pop = cyc;
        end
        if (occ > max_occ) max_occ = occ;
        @(posedge clk);
        #1;
        cyc++;
        dram_valid = 1'b0;
        real_v = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            dram_data_rd = dword(req_q.pop_front());
            dram_valid = 1'b1;
            real_v = 1'b1;
        end else if (stray) begin
            dram_data_rd = 32'hDEAD_BEEF;
            dram_valid = 1'b1;
            stray = 1'b0;
        end
    endtask

    task automatic clr();
        rd_addr.delete();
        rd_cyc.delete();
        got.delete();
        occ = 0;
        max_occ = 0;
    endtask

    task automatic go(input logic [AW-1:0] b, input int l);
        base_addr = b;
        length = l[LW-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_in_budget"}, done, 1);
    endtask

    task automatic seq_chk(input string tag, input logic [AW-1:0] b, input int n);
        int bad_a = 0, bad_d = 0;
        logic [AW-1:0] e;
        chk({tag, "_reads"}, rd_addr.size(), n);
        chk({tag, "_words"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            e = b + AW'(i);
            if (i < rd_addr.size() && rd_addr[i] !== e) bad_a++;
            if (i < got.size() && got[i] !== dword(e)) bad_d++;
        end
        chk({tag, "_addr_seq"}, bad_a, 0);
        chk({tag, "_data_seq"}, bad_d, 0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", dram_en_rd, 0);
        chk("rst_addr", dram_addr_rd, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err_unexp, 0);
        arst = 1'b0;
        step();

        clr(); lat = 2; out_ready = 1'b1;
        go(18'h100, 4);
        chk("t1_busy_t1", busy, 1);
        chk("t1_en_t1", dram_en_rd, 1);
        chk("t1_addr_t1", dram_addr_rd, 18'h100);
        wait_done("t1", 40);
        chk("t1_done_after_last_pop", cyc, last_pop + 1);
        seq_chk("t1", 18'h100, 4);
        chk("t1_consecutive", (rd_cyc.size() == 4) ? rd_cyc[3] - rd_cyc[0] : -1, 3);
        step();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_busy_low", busy, 0);

        clr(); lat = 3; out_ready = 1'b0;
        go(18'h200, 20);
        repeat (30) step();
        chk("t2_stall_reads", rd_addr.size(), 8);
        chk("t2_head_valid", out_valid, 1);
        chk("t2_head_data", out_data, dword(18'h200));
        chk("t2_no_pops", got.size(), 0);
        out_ready = 1'b1;
        wait_done("t2", 100);
        seq_chk("t2", 18'h200, 20);
        chk("t2_max_occ", max_occ, 8);
        step();

        clr(); lat = 1;
        go(18'h3FFFE, 4);
        wait_done("t3", 40);
        seq_chk("t3", 18'h3FFFE, 4);
        step();

        clr();
        go(18'h55, 0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        step();
        chk("t4_done_once", done, 0);
        chk("t4_busy_after", busy, 0);
        chk("t4_no_reads", rd_addr.size(), 0);

        clr(); lat = 2;
        go(18'h80, 6);
        step(); step();
        base_addr = 18'h40; length = 16'd6; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t5", 60);
        seq_chk("t5", 18'h80, 6);
        repeat (5) step();
        chk("t5_idle_after", busy, 0);
        chk("t5_no_extra_reads", rd_addr.size(), 6);

        clr();
        stray = 1'b1;
        step();
        step();
        chk("t6_err_set", err_unexp, 1);
        chk("t6_no_out", out_valid, 0);
        step();
        chk("t6_err_sticky", err_unexp, 1);
        chk("t6_still_empty", out_valid, 0);
        go(18'h300, 10);
        repeat (3) step();
        chk("t6_busy_mid", busy, 1);
        arst = 1'b1;
        #1;
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_en", dram_en_rd, 0);
        chk("t6_arst_addr", dram_addr_rd, 0);
        chk("t6_arst_out_valid", out_valid, 0);
        chk("t6_arst_out_data", out_data, 0);
        chk("t6_arst_err", err_unexp, 0);
        req_q.delete(); due_q.delete();
        dram_valid = 1'b0; real_v = 1'b0;
        step(); step();
        arst = 1'b0;
        step(); step();
        chk("t6_post_busy", busy, 0);
        chk("t6_post_err", err_unexp, 0);
        chk("t6_post_en", dram_en_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
